// File: rtl/rf_update_arbiter.sv
// Arbitrates the register file's single update port between ROB commits and
// buffered rename requests, with a starvation guard so queued renames always drain.
module rf_update_arbiter #(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 3,
  parameter int REG_W        = 5,
  parameter int TAG_W        = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             rollback,
  input  logic             cm_valid,
  output logic             cm_ready,
  input  logic [REG_W-1:0] cm_rd,
  input  logic [TAG_W-1:0] cm_tag,
  input  logic [31:0]      cm_val,
  input  logic             rn_valid,
  output logic             rn_ready,
  input  logic [REG_W-1:0] rn_rd,
  input  logic [TAG_W-1:0] rn_tag,
  output logic             rf_cm_valid,
  output logic [REG_W-1:0] rf_cm_rd,
  output logic [TAG_W-1:0] rf_cm_tag,
  output logic [31:0]      rf_cm_val,
  output logic             rf_rn_valid,
  output logic [REG_W-1:0] rf_rn_rd,
  output logic [TAG_W-1:0] rf_rn_tag,
  output logic             rn_pending
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int ST_W  = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
  localparam logic [ST_W-1:0]  STARVE_C = ST_W'(STARVE_LIMIT);

  typedef struct packed {
    logic [REG_W-1:0] rd;
    logic [TAG_W-1:0] tag;
  } rn_ent_t;

  rn_ent_t          mem_q [DEPTH];
  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [ST_W-1:0]  starve_q, starve_d;

  logic             rf_cm_valid_q, rf_cm_valid_d, rf_rn_valid_q, rf_rn_valid_d;
  logic [REG_W-1:0] rf_cm_rd_q, rf_cm_rd_d, rf_rn_rd_q, rf_rn_rd_d;
  logic [TAG_W-1:0] rf_cm_tag_q, rf_cm_tag_d, rf_rn_tag_q, rf_rn_tag_d;
  logic [31:0]      rf_cm_val_q, rf_cm_val_d;

  logic fifo_nonempty, force_rn, cm_win, rn_take, bypass, push, pop;

  assign fifo_nonempty = (count_q != '0);
  assign force_rn      = fifo_nonempty && (starve_q == STARVE_C);
  assign cm_ready      = rdy && !rollback && !force_rn;
  // Uses registered count: a full FIFO refuses a push even if it pops this cycle.
  assign rn_ready      = rdy && !rollback && (count_q < DEPTH_C);

  assign cm_win  = cm_valid && cm_ready && (cm_rd != '0);
  assign rn_take = rn_valid && rn_ready && (rn_rd != '0);
  assign pop     = rdy && !rollback && !cm_win && fifo_nonempty;
  assign bypass  = rn_take && !cm_win && !fifo_nonempty;
  assign push    = rn_take && !bypass;

  always_comb begin
    head_d        = head_q;
    tail_d        = tail_q;
    count_d       = count_q;
    starve_d      = starve_q;
    rf_cm_valid_d = rf_cm_valid_q;
    rf_cm_rd_d    = rf_cm_rd_q;
    rf_cm_tag_d   = rf_cm_tag_q;
    rf_cm_val_d   = rf_cm_val_q;
    rf_rn_valid_d = rf_rn_valid_q;
    rf_rn_rd_d    = rf_rn_rd_q;
    rf_rn_tag_d   = rf_rn_tag_q;
    if (rdy) begin
      if (rollback) begin
        head_d        = '0;
        tail_d        = '0;
        count_d       = '0;
        starve_d      = '0;
        rf_cm_valid_d = 1'b0;
        rf_rn_valid_d = 1'b0;
      end else begin
        rf_cm_valid_d = cm_win;
        rf_rn_valid_d = pop || bypass;
        if (cm_win) begin
          rf_cm_rd_d  = cm_rd;
          rf_cm_tag_d = cm_tag;
          rf_cm_val_d = cm_val;
        end
        if (pop) begin
          rf_rn_rd_d  = mem_q[head_q].rd;
          rf_rn_tag_d = mem_q[head_q].tag;
          head_d      = head_q + PTR_W'(1);
        end else if (bypass) begin
          rf_rn_rd_d  = rn_rd;
          rf_rn_tag_d = rn_tag;
        end
        if (push) tail_d = tail_q + PTR_W'(1);
        if (push && !pop)      count_d = count_q + CNT_W'(1);
        else if (pop && !push) count_d = count_q - CNT_W'(1);
        // Only commits that beat a waiting head count toward starvation.
        if (!fifo_nonempty || pop)              starve_d = '0;
        else if (cm_win && starve_q != STARVE_C) starve_d = starve_q + ST_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[tail_q] <= '{rd: rn_rd, tag: rn_tag};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q        <= '0;
      tail_q        <= '0;
      count_q       <= '0;
      starve_q      <= '0;
      rf_cm_valid_q <= 1'b0;
      rf_cm_rd_q    <= '0;
      rf_cm_tag_q   <= '0;
      rf_cm_val_q   <= '0;
      rf_rn_valid_q <= 1'b0;
      rf_rn_rd_q    <= '0;
      rf_rn_tag_q   <= '0;
    end else begin
      head_q        <= head_d;
      tail_q        <= tail_d;
      count_q       <= count_d;
      starve_q      <= starve_d;
      rf_cm_valid_q <= rf_cm_valid_d;
      rf_cm_rd_q    <= rf_cm_rd_d;
      rf_cm_tag_q   <= rf_cm_tag_d;
      rf_cm_val_q   <= rf_cm_val_d;
      rf_rn_valid_q <= rf_rn_valid_d;
      rf_rn_rd_q    <= rf_rn_rd_d;
      rf_rn_tag_q   <= rf_rn_tag_d;
    end
  end

  assign rf_cm_valid = rf_cm_valid_q;
  assign rf_cm_rd    = rf_cm_rd_q;
  assign rf_cm_tag   = rf_cm_tag_q;
  assign rf_cm_val   = rf_cm_val_q;
  assign rf_rn_valid = rf_rn_valid_q;
  assign rf_rn_rd    = rf_rn_rd_q;
  assign rf_rn_tag   = rf_rn_tag_q;
  assign rn_pending  = fifo_nonempty || rf_rn_valid_q;

endmodule

// File: tb/tb_rf_update_arbiter.sv
// Directed table-driven bench for rf_update_arbiter plus hand sequences for
// starvation forcing and mid-operation reset.
module tb_rf_update_arbiter;

  logic        clk = 1'b0;
  logic        rst, rdy, rollback;
  logic        cm_valid, cm_ready, rn_valid, rn_ready;
  logic [4:0]  cm_rd, cm_tag, rn_rd, rn_tag;
  logic [31:0] cm_val;
  logic        rf_cm_valid, rf_rn_valid, rn_pending;
  logic [4:0]  rf_cm_rd, rf_cm_tag, rf_rn_rd, rf_rn_tag;
  logic [31:0] rf_cm_val;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rf_update_arbiter #(.DEPTH(4), .STARVE_LIMIT(3), .REG_W(5), .TAG_W(5)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback),
    .cm_valid(cm_valid), .cm_ready(cm_ready), .cm_rd(cm_rd), .cm_tag(cm_tag), .cm_val(cm_val),
    .rn_valid(rn_valid), .rn_ready(rn_ready), .rn_rd(rn_rd), .rn_tag(rn_tag),
    .rf_cm_valid(rf_cm_valid), .rf_cm_rd(rf_cm_rd), .rf_cm_tag(rf_cm_tag), .rf_cm_val(rf_cm_val),
    .rf_rn_valid(rf_rn_valid), .rf_rn_rd(rf_rn_rd), .rf_rn_tag(rf_rn_tag),
    .rn_pending(rn_pending)
  );

  typedef struct packed {
    logic        rdy, rb, cv;
    logic [4:0]  crd, ctag;
    logic [31:0] cval;
    logic        rv;
    logic [4:0]  rrd, rtag;
    logic        e_cmr, e_rnr, e_cmv;
    logic [4:0]  e_cmrd, e_cmtag;
    logic [31:0] e_cmval;
    logic        e_rnv;
    logic [4:0]  e_rnrd, e_rntag;
    logic        e_pend;
  } vec_t;

  localparam int NV = 28;
  vec_t vecs [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic rb, input logic cv, input logic [4:0] crd,
                       input logic [4:0] ctag, input logic [31:0] cval, input logic rv,
                       input logic [4:0] rrd, input logic [4:0] rtag);
    rdy = r; rollback = rb; cm_valid = cv; cm_rd = crd; cm_tag = ctag; cm_val = cval;
    rn_valid = rv; rn_rd = rrd; rn_tag = rtag;
  endtask

  task automatic apply(input vec_t v, input int idx);
    drive(v.rdy, v.rb, v.cv, v.crd, v.ctag, v.cval, v.rv, v.rrd, v.rtag);
    #1;
    chk($sformatf("v%0d cm_ready", idx), 32'(cm_ready), 32'(v.e_cmr));
    chk($sformatf("v%0d rn_ready", idx), 32'(rn_ready), 32'(v.e_rnr));
    @(posedge clk); #1;
    chk($sformatf("v%0d rf_cm_valid", idx), 32'(rf_cm_valid), 32'(v.e_cmv));
    chk($sformatf("v%0d rf_rn_valid", idx), 32'(rf_rn_valid), 32'(v.e_rnv));
    chk($sformatf("v%0d rn_pending", idx), 32'(rn_pending), 32'(v.e_pend));
    if (v.e_cmv) begin
      chk($sformatf("v%0d rf_cm_rd", idx), 32'(rf_cm_rd), 32'(v.e_cmrd));
      chk($sformatf("v%0d rf_cm_tag", idx), 32'(rf_cm_tag), 32'(v.e_cmtag));
      chk($sformatf("v%0d rf_cm_val", idx), rf_cm_val, v.e_cmval);
    end
    if (v.e_rnv) begin
      chk($sformatf("v%0d rf_rn_rd", idx), 32'(rf_rn_rd), 32'(v.e_rnrd));
      chk($sformatf("v%0d rf_rn_tag", idx), 32'(rf_rn_tag), 32'(v.e_rntag));
    end
    $display("vec %0d: cm_rdy=%0b rn_rdy=%0b -> cm_v=%0b rn_v=%0b rn_rd=%0d pend=%0b",
             idx, v.e_cmr, v.e_rnr, rf_cm_valid, rf_rn_valid, rf_rn_rd, rn_pending);
  endtask

  initial begin
    // rdy rb cv crd ctag cval     rv rrd rtag | cmr rnr cmv cmrd cmtag cmval    rnv rnrd rntag pend
    vecs[0]  = '{1,0,0, 0, 0, 0,        1, 5, 3,  1,1, 0, 0, 0, 0,        1, 5, 3, 1};
    vecs[1]  = '{1,0,0, 0, 0, 0,        0, 0, 0,  1,1, 0, 0, 0, 0,        0, 0, 0, 0};
    vecs[2]  = '{1,0,1, 7, 2, 'hDEAD,   1, 8, 4,  1,1, 1, 7, 2, 'hDEAD,   0, 0, 0, 1};
    vecs[3]  = '{1,0,0, 0, 0, 0,        0, 0, 0,  1,1, 0, 0, 0, 0,        1, 8, 4, 1};
    vecs[4]  = '{1,0,0, 0, 0, 0,        0, 0, 0,  1,1, 0, 0, 0, 0,        0, 0, 0, 0};
    vecs[5]  = '{1,0,1, 1, 1, 'h11,     1, 9, 9,  1,1, 1, 1, 1, 'h11,     0, 0, 0, 1};
    vecs[6]  = '{1,0,1, 2, 2, 'h22,     1,10,10,  1,1, 1, 2, 2, 'h22,     0, 0, 0, 1};
    vecs[7]  = '{1,0,1, 3, 3, 'h33,     1,11,11,  1,1, 1, 3, 3, 'h33,     0, 0, 0, 1};
    vecs[8]  = '{1,0,1, 4, 4, 'h44,     1,12,12,  1,1, 1, 4, 4, 'h44,     0, 0, 0, 1};
    vecs[9]  = '{1,0,1, 5, 5, 'h55,     1,13,13,  0,0, 0, 0, 0, 0,        1, 9, 9, 1};
    vecs[10] = '{1,0,1, 5, 5, 'h55,     1,13,13,  1,1, 1, 5, 5, 'h55,     0, 0, 0, 1};
    vecs[11] = '{1,0,0, 0, 0, 0,        0, 0, 0,  1,0, 0, 0, 0, 0,        1,10,10, 1};
    vecs[12] = '{1,0,0, 0, 0, 0,        0, 0, 0,  1,1, 0, 0, 0, 0,        1,11,11, 1};
    vecs[13] = '{1,0,0, 0, 0, 0,        0, 0, 0,  1,1, 0, 0, 0, 0,        1,12,12, 1};
    vecs[14] = '{1,0,0, 0, 0, 0,        0, 0, 0,  1,1, 0, 0, 0, 0,        1,13,13, 1};
    vecs[15] = '{1,0,0, 0, 0, 0,        0, 0, 0,  1,1, 0, 0, 0, 0,        0, 0, 0, 0};
    vecs[16] = '{1,0,1, 6, 6, 'h66,     1,14,14,  1,1, 1, 6, 6, 'h66,     0, 0, 0, 1};
    vecs[17] = '{1,0,1, 7, 7, 'h77,     1,15,15,  1,1, 1, 7, 7, 'h77,     0, 0, 0, 1};
    vecs[18] = '{1,0,1, 8, 8, 'h88,     1,16,16,  1,1, 1, 8, 8, 'h88,     0, 0, 0, 1};
    vecs[19] = '{1,1,1, 9, 9, 'h99,     1,17,17,  0,0, 0, 0, 0, 0,        0, 0, 0, 0};
    vecs[20] = '{1,0,0, 0, 0, 0,        0, 0, 0,  1,1, 0, 0, 0, 0,        0, 0, 0, 0};
    vecs[21] = '{1,0,0, 0, 0, 0,        0, 0, 0,  1,1, 0, 0, 0, 0,        0, 0, 0, 0};
    vecs[22] = '{1,0,1, 0, 1, 'hBAD,    1, 0, 2,  1,1, 0, 0, 0, 0,        0, 0, 0, 0};
    vecs[23] = '{1,0,1, 0, 1, 'hBAD,    1,20,21,  1,1, 0, 0, 0, 0,        1,20,21, 1};
    vecs[24] = '{0,0,1, 3, 1, 'h1,      1, 4, 4,  0,0, 0, 0, 0, 0,        1,20,21, 1};
    vecs[25] = '{0,0,1, 3, 1, 'h1,      1, 4, 4,  0,0, 0, 0, 0, 0,        1,20,21, 1};
    vecs[26] = '{0,0,1, 3, 1, 'h1,      1, 4, 4,  0,0, 0, 0, 0, 0,        1,20,21, 1};
    vecs[27] = '{1,0,0, 0, 0, 0,        0, 0, 0,  1,1, 0, 0, 0, 0,        0, 0, 0, 0};

    rst = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("reset rf_cm_valid", 32'(rf_cm_valid), 32'd0);
    chk("reset rf_rn_valid", 32'(rf_rn_valid), 32'd0);
    chk("reset rf_cm_val", rf_cm_val, 32'd0);
    chk("reset rf_rn_rd", 32'(rf_rn_rd), 32'd0);
    chk("reset rn_pending", 32'(rn_pending), 32'd0);
    $display("reset: cm_v=%0b rn_v=%0b pend=%0b", rf_cm_valid, rf_rn_valid, rn_pending);
    rst = 1'b0;

    for (int i = 0; i < NV; i++) apply(vecs[i], i);

    // Starvation: one queued rename under continuous commits.
    drive(1'b1, 1'b0, 1'b1, 5'd1, 5'd1, 32'h100, 1'b1, 5'd25, 5'd26);
    #1;
    chk("starve push cm_ready", 32'(cm_ready), 32'd1);
    @(posedge clk); #1;
    chk("starve push rf_cm_valid", 32'(rf_cm_valid), 32'd1);
    begin
      int k;
      k = 2;
      for (int i = 0; i < 10; i++) begin
        drive(1'b1, 1'b0, 1'b1, 5'(k), 5'(k), 32'(k) + 32'h100, 1'b0, 5'd0, 5'd0);
        #1;
        chk($sformatf("starve%0d cm_ready", i), 32'(cm_ready), (i == 3) ? 32'd0 : 32'd1);
        @(posedge clk); #1;
        if (i == 3) begin
          chk($sformatf("starve%0d rf_rn_valid", i), 32'(rf_rn_valid), 32'd1);
          chk($sformatf("starve%0d rf_rn_rd", i), 32'(rf_rn_rd), 32'd25);
          chk($sformatf("starve%0d rf_rn_tag", i), 32'(rf_rn_tag), 32'd26);
          chk($sformatf("starve%0d rf_cm_valid", i), 32'(rf_cm_valid), 32'd0);
        end else begin
          chk($sformatf("starve%0d rf_cm_valid", i), 32'(rf_cm_valid), 32'd1);
          chk($sformatf("starve%0d rf_cm_rd", i), 32'(rf_cm_rd), 32'(k));
          chk($sformatf("starve%0d rf_rn_valid", i), 32'(rf_rn_valid), 32'd0);
          k++;
        end
        $display("starve %0d: cm_v=%0b rn_v=%0b", i, rf_cm_valid, rf_rn_valid);
      end
    end

    // Mid-operation reset discards a queued rename and clears outputs.
    drive(1'b1, 1'b0, 1'b1, 5'd3, 5'd3, 32'h300, 1'b1, 5'd6, 5'd6);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst rf_cm_valid", 32'(rf_cm_valid), 32'd0);
    chk("midrst rf_cm_rd", 32'(rf_cm_rd), 32'd0);
    chk("midrst rn_pending", 32'(rn_pending), 32'd0);
    rst = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0);
    @(posedge clk); #1;
    chk("midrst after rf_rn_valid", 32'(rf_rn_valid), 32'd0);
    chk("midrst after rn_pending", 32'(rn_pending), 32'd0);
    $display("midrst: rn_v=%0b pend=%0b", rf_rn_valid, rn_pending);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
